// File: rtl/seg_capture.sv
// seg_capture
// Recovers the digits shown on a multiplexed, active-low 4-digit
// 7-segment display by watching its anode and segment lines.
//
// Each anode/segment pattern must hold for STABLE_CYCLES identical
// synchronized samples before it is accepted. The accepted digit is
// decoded and written into a shadow frame. Once all four digits are
// present, the shadow frame is published on value/digit_err. The
// publish is marked by a one-cycle frame_valid pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (released synchronously)
//   an_in[3:0]   digit enables, active-low, bit i selects digit i
//   seg_in[6:0]  segments a..g on bits 6..0, active-low
//   value[15:0]  last completed frame, digit i in bits [4i+3:4i]
//   digit_err    per-digit illegal-pattern flags for that frame
//   frame_valid  one-cycle pulse when value/digit_err update
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_HELD    = 2'd1;
  localparam logic [1:0] ST_INVALID = 2'd2;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  // A capture fires on the edge where the counter moves from here to STABLE_CYCLES-1.
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  // Reset is asserted asynchronously but released on a clock edge.
  // This keeps every state flop leaving reset in the same cycle.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
  logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic        commit_q, commit_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  digit_err_q, digit_err_d;
  logic        frame_valid_q, frame_valid_d;

  logic        sample_chg;
  logic        one_hot;
  logic [1:0]  dig_sel;
  logic        capture;
  logic [3:0]  dec_nib;
  logic        dec_err;

  // Segment decode of the synchronized sample; anything unknown maps to E.
  always_comb begin
    dec_nib = 4'hE;
    dec_err = 1'b1;
    case (seg_s2_q)
      7'h01: begin dec_nib = 4'h0; dec_err = 1'b0; end
      7'h4F: begin dec_nib = 4'h1; dec_err = 1'b0; end
      7'h12: begin dec_nib = 4'h2; dec_err = 1'b0; end
      7'h06: begin dec_nib = 4'h3; dec_err = 1'b0; end
      7'h4C: begin dec_nib = 4'h4; dec_err = 1'b0; end
      7'h24: begin dec_nib = 4'h5; dec_err = 1'b0; end
      7'h20: begin dec_nib = 4'h6; dec_err = 1'b0; end
      7'h0F: begin dec_nib = 4'h7; dec_err = 1'b0; end
      7'h00: begin dec_nib = 4'h8; dec_err = 1'b0; end
      7'h04: begin dec_nib = 4'h9; dec_err = 1'b0; end
      7'h7F: begin dec_nib = 4'hF; dec_err = 1'b0; end
      default: ;
    endcase
  end

  // Only a single low anode bit names a digit; every other pattern is invalid.
  always_comb begin
    one_hot = 1'b1;
    dig_sel = 2'd0;
    case (an_s2_q)
      4'b1110: dig_sel = 2'd0;
      4'b1101: dig_sel = 2'd1;
      4'b1011: dig_sel = 2'd2;
      4'b0111: dig_sel = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    an_s1_d    = an_in;
    seg_s1_d   = seg_in;
    an_s2_d    = an_s1_q;
    seg_s2_d   = seg_s1_q;
    an_prev_d  = an_s2_q;
    seg_prev_d = seg_s2_q;

    sample_chg = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);

    // The counter saturates, so it passes CNT_CAP at most once per stable period.
    cnt_d = cnt_q;
    if (sample_chg) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    capture = (state_q == ST_SETTLE) && !sample_chg && (cnt_q == CNT_CAP) && one_hot;

    state_d = state_q;
    if (!one_hot) begin
      state_d = ST_INVALID;
    end else begin
      case (state_q)
        ST_SETTLE:  if (capture) state_d = ST_HELD;
        ST_HELD:    if (sample_chg) state_d = ST_SETTLE;
        ST_INVALID: state_d = ST_SETTLE;
        default:    state_d = ST_SETTLE;
      endcase
    end

    // A commit clears seen first, so a capture landing in the commit cycle
    // becomes the first digit of the next frame. The publish below reads the
    // old shadow registers, not this cycle's write.
    seen_d       = commit_q ? 4'h0 : seen_q;
    shadow_val_d = shadow_val_q;
    shadow_err_d = shadow_err_q;
    if (capture) begin
      seen_d[dig_sel]                    = 1'b1;
      shadow_val_d[{dig_sel, 2'b00} +: 4] = dec_nib;
      shadow_err_d[dig_sel]              = dec_err;
    end
    commit_d = capture && (seen_d == 4'hF);

    value_d       = commit_q ? shadow_val_q : value_q;
    digit_err_d   = commit_q ? shadow_err_q : digit_err_q;
    frame_valid_d = commit_q;
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      an_s1_q       <= 4'hF;
      seg_s1_q      <= 7'h7F;
      an_s2_q       <= 4'hF;
      seg_s2_q      <= 7'h7F;
      an_prev_q     <= 4'hF;
      seg_prev_q    <= 7'h7F;
      cnt_q         <= 8'd0;
      state_q       <= ST_SETTLE;
      seen_q        <= 4'h0;
      shadow_val_q  <= 16'h0000;
      shadow_err_q  <= 4'h0;
      commit_q      <= 1'b0;
      value_q       <= 16'h0000;
      digit_err_q   <= 4'h0;
      frame_valid_q <= 1'b0;
    end else begin
      an_s1_q       <= an_s1_d;
      seg_s1_q      <= seg_s1_d;
      an_s2_q       <= an_s2_d;
      seg_s2_q      <= seg_s2_d;
      an_prev_q     <= an_prev_d;
      seg_prev_q    <= seg_prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      seen_q        <= seen_d;
      shadow_val_q  <= shadow_val_d;
      shadow_err_q  <= shadow_err_d;
      commit_q      <= commit_d;
      value_q       <= value_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture
// Self-checking bench for seg_capture with STABLE_CYCLES=4.
// A reference model predicts the outputs from raw input history. It tracks
// runs of identical raw samples and the fixed pipeline delay behind them.
// The outputs are compared on every falling edge. Table vectors, directed
// corner sequences and a randomized scan then exercise the block.
module tb_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails = 0;
  int frame_cnt = 0;

  logic [6:0] legal_seg [11] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                                 7'h20, 7'h0F, 7'h00, 7'h04, 7'h7F};
  logic [3:0] legal_nib [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] nib, output logic err);
    nib = 4'hE;
    err = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (legal_seg[k] == s) begin
        nib = legal_nib[k];
        err = 1'b0;
      end
    end
  endfunction

  // Reference model. A digit is accepted when a one-hot raw sample repeats
  // for S consecutive edges. It lands in the shadow frame two edges later,
  // after the synchronizer. A completed frame is published one edge after that.
  typedef struct { int at; int dig; logic [6:0] seg; } cap_t;
  cap_t        capq[$];
  int          edge_n = 0;
  int          run_len = 0;
  logic [10:0] prev_raw = '1;
  logic [15:0] m_shadow = '0, m_value = '0;
  logic [3:0]  m_sh_err = '0, m_err = '0, m_seen = '0;
  logic        m_fv = 1'b0, m_commit = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    cap_t       c;
    logic [3:0] nib;
    logic       err;
    int         d;
    if (!rst_n) begin
      capq.delete();
      edge_n = 0;
      run_len = 0;
      prev_raw = '1;
      m_shadow = '0; m_sh_err = '0; m_seen = '0;
      m_value = '0; m_err = '0; m_fv = 1'b0; m_commit = 1'b0;
    end else begin
      edge_n++;
      m_fv = 1'b0;
      if (m_commit) begin
        m_value = m_shadow;
        m_err = m_sh_err;
        m_fv = 1'b1;
        m_seen = '0;
        m_commit = 1'b0;
      end
      if (capq.size() > 0 && capq[0].at == edge_n) begin
        c = capq.pop_front();
        ref_decode(c.seg, nib, err);
        m_shadow[c.dig*4 +: 4] = nib;
        m_sh_err[c.dig] = err;
        m_seen[c.dig] = 1'b1;
        if (m_seen == 4'hF) m_commit = 1'b1;
      end
      if ({an_in, seg_in} == prev_raw) run_len++;
      else run_len = 1;
      prev_raw = {an_in, seg_in};
      if (run_len == S && $countones(~an_in) == 1) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (!an_in[k]) d = k;
        c.at = edge_n + 2;
        c.dig = d;
        c.seg = seg_in;
        capq.push_back(c);
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_output("value", 32'(value), 32'(m_value));
    check_output("digit_err", 32'(digit_err), 32'(m_err));
    check_output("frame_valid", 32'(frame_valid), 32'(m_fv));
    if (frame_valid === 1'b1) frame_cnt++;
  end

  task automatic apply_stimulus(input logic [3:0] an, input logic [6:0] seg, input int hold);
    @(negedge clk);
    an_in = an;
    seg_in = seg;
    repeat (hold) @(posedge clk);
  endtask

  task automatic show_digit(input int dig, input logic [6:0] seg, input int hold);
    apply_stimulus(4'(~(4'b0001 << dig)), seg, hold);
  endtask

  task automatic idle(input int n);
    apply_stimulus(4'hF, 7'h7F, n);
  endtask

  typedef struct {
    logic [3:0][6:0] seg;
    int              hold;
    logic [15:0]     exp_value;
    logic [3:0]      exp_err;
    int              exp_frames;
  } vec_t;

  vec_t vecs[6];
  int   f0;

  initial begin
    rst_n = 1'b0;
    an_in = 4'hF;
    seg_in = 7'h7F;

    vecs[0] = '{seg: {7'h4C, 7'h06, 7'h12, 7'h4F}, hold: 8, exp_value: 16'h4321, exp_err: 4'h0, exp_frames: 1};
    vecs[1] = '{seg: {7'h01, 7'h7E, 7'h01, 7'h01}, hold: 8, exp_value: 16'h0E00, exp_err: 4'b0100, exp_frames: 1};
    vecs[2] = '{seg: {7'h4C, 7'h06, 7'h12, 7'h4F}, hold: 3, exp_value: 16'h0E00, exp_err: 4'b0100, exp_frames: 0};
    vecs[3] = '{seg: {7'h0F, 7'h20, 7'h04, 7'h00}, hold: 6, exp_value: 16'h7698, exp_err: 4'h0, exp_frames: 1};
    vecs[4] = '{seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, hold: 5, exp_value: 16'hFFFF, exp_err: 4'h0, exp_frames: 1};
    vecs[5] = '{seg: {7'h3F, 7'h04, 7'h08, 7'h01}, hold: S, exp_value: 16'hE9E0, exp_err: 4'b1010, exp_frames: 1};

    repeat (3) @(negedge clk);
    check_output("reset_value", 32'(value), 32'h0);
    rst_n = 1'b1;
    idle(6);

    for (int v = 0; v < 6; v++) begin
      f0 = frame_cnt;
      for (int i = 0; i < 4; i++) show_digit(i, vecs[v].seg[i], vecs[v].hold);
      idle(10);
      check_output($sformatf("vec%0d_frames", v), 32'(frame_cnt - f0), 32'(vecs[v].exp_frames));
      check_output($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_value));
      check_output($sformatf("vec%0d_err", v), 32'(digit_err), 32'(vecs[v].exp_err));
    end

    // A non-one-hot anode between legal digits is ignored; the frame still completes.
    f0 = frame_cnt;
    show_digit(0, 7'h4F, 8);
    show_digit(1, 7'h12, 8);
    apply_stimulus(4'b0101, 7'h06, 10);
    show_digit(2, 7'h06, 8);
    show_digit(3, 7'h4C, 8);
    idle(10);
    check_output("invalid_an_frames", 32'(frame_cnt - f0), 32'd1);
    check_output("invalid_an_value", 32'(value), 32'h4321);

    // Recapturing digit 1 overwrites its shadow slot.
    f0 = frame_cnt;
    show_digit(0, 7'h01, 8);
    show_digit(1, 7'h24, 8);
    show_digit(1, 7'h20, 8);
    show_digit(2, 7'h01, 8);
    show_digit(3, 7'h01, 8);
    idle(10);
    check_output("recapture_frames", 32'(frame_cnt - f0), 32'd1);
    check_output("recapture_digit1", 32'(value[7:4]), 32'h6);

    // The completing digit's raw change reaches frame_valid after S+3 edges.
    show_digit(0, 7'h4C, 8);
    show_digit(1, 7'h24, 8);
    show_digit(2, 7'h00, 8);
    idle(10);
    @(negedge clk);
    an_in = 4'b0111;
    seg_in = 7'h04;
    repeat (S + 2) @(posedge clk);
    #1 check_output("latency_early", 32'(frame_valid), 32'd0);
    @(posedge clk);
    #1 check_output("latency_hit", 32'(frame_valid), 32'd1);
    check_output("latency_value", 32'(value), 32'h9854);
    repeat (2) @(posedge clk);
    idle(10);

    // Reset mid-frame discards partial captures. Digits 1..3 alone after
    // release must not complete a frame.
    show_digit(0, 7'h4F, 8);
    show_digit(1, 7'h12, 8);
    show_digit(2, 7'h06, 8);
    idle(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_value", 32'(value), 32'h0);
    check_output("async_rst_err", 32'(digit_err), 32'h0);
    check_output("async_rst_fv", 32'(frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    f0 = frame_cnt;
    show_digit(1, 7'h7F, 8);
    show_digit(2, 7'h7F, 8);
    show_digit(3, 7'h7F, 8);
    idle(10);
    check_output("post_rst_partial_frames", 32'(frame_cnt - f0), 32'd0);
    show_digit(0, 7'h7F, 8);
    idle(10);
    check_output("post_rst_frames", 32'(frame_cnt - f0), 32'd1);
    check_output("post_rst_value", 32'(value), 32'hFFFF);

    // Randomized scan, checked cycle by cycle against the model.
    for (int r = 0; r < 400; r++) begin
      logic [3:0] an;
      logic [6:0] sg;
      if ($urandom_range(0, 3) != 0) an = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else an = 4'($urandom);
      if ($urandom_range(0, 9) < 7) sg = legal_seg[$urandom_range(0, 10)];
      else sg = 7'($urandom);
      apply_stimulus(an, sg, int'($urandom_range(1, 10)));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
